ecc_add_arbiter: RTL
====================

Name: ecc_add_arbiter

Overview:
Shares one elliptic-curve point-add unit (256-bit operands, in_valid/out_valid pulse handshake) among NREQ requesters, for example a scalar-multiply engine and a signature-verify engine. Round-robin arbitration; one add operation in flight at a time. Latches the winner's operands, issues the add, holds operands stable while it runs, and routes the result back to the owning requester.

Parameters:
NREQ, 2, number of requesters (1..8)
W, 256, coordinate width in bits
TIMEOUT_CYC, 4096, watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous and active-high; one clock only
req_valid  in  NREQ  per-requester request
req_ready  out  NREQ  per-requester accept; at most one bit high
req_Px, req_Py, req_Qx, req_Qy  in  NREQ*W each  flattened operands; slice i = [i*W +: W]
resp_valid  out  NREQ  one-hot, one-cycle result strobe
resp_Rx, resp_Ry  out  W each  result, shared by all requesters, qualified by resp_valid
resp_err  out  1  timeout flag, qualified by resp_valid; tied 0 without macro
busy  out  1  high whenever state != IDLE
add_in_valid  out  1  one-cycle start pulse to the add unit
add_Px, add_Py, add_Qx, add_Qy  out  W each  operands to the add unit
add_Rx, add_Ry  in  W each  add unit result
add_out_valid  in  1  add unit done pulse

Behaviour:
- Reset: state=IDLE, rr_ptr=0, owner=0. All outputs 0, including the operand and result registers.
- States: IDLE, ISSUE, BUSY, RESP (plus DRAIN when the macro is defined).
- IDLE:
  - Winner = first index i with req_valid[i]=1, searching from rr_ptr upward and wrapping mod NREQ.
  - req_ready[winner]=1 combinationally in the same cycle; this is the accept cycle.
  - On accept: latch the winner's four operands into op regs, owner<=winner, go to ISSUE.
  - If there are no requests, stay in IDLE.
- ISSUE: add_in_valid=1 for exactly this cycle, then go to BUSY.
- BUSY: on add_out_valid, capture add_Rx/add_Ry into resp_Rx/resp_Ry and go to RESP.
- add_Px..add_Qy are driven from the op regs and are stable from ISSUE through the end of BUSY. They are 0 in IDLE and RESP.
- RESP: resp_valid[owner]=1 for one cycle, rr_ptr<=(owner+1) mod NREQ, then go to IDLE.
- resp_Rx/resp_Ry hold their value until the next capture.
- Latency: accept at cycle t; add_in_valid at t+1; add unit latency L gives add_out_valid at t+1+L; resp_valid at t+2+L. The next accept is possible at t+3+L.
- Requester rules:
  - Operands must be held stable while req_valid=1 and ready=0.
  - Dropping req_valid before ready is a legal withdrawal.
- add_out_valid outside BUSY is ignored, including stale pulses after a reset mid-operation.
- Reset mid-operation: the operation is abandoned and no resp_valid is produced. rst also resets the add unit at top level.
- If all requesters are valid simultaneously, grants are strictly round-robin; no requester waits more than NREQ-1 operations.
- NREQ=1 degenerates to a pass-through sequencer with rr_ptr fixed at 0.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on ISSUE and increments in BUSY.
  - If it reaches TIMEOUT_CYC-1 without add_out_valid, go to RESP with resp_err=1 and resp_Rx=resp_Ry=0.
  - After that RESP the FSM goes to DRAIN instead of IDLE.
  - DRAIN waits for the stale add_out_valid, or for another TIMEOUT_CYC cycles, then goes to IDLE. No accepts occur in DRAIN.
  - busy stays high in DRAIN.
- Undefined: no counter, no DRAIN state, resp_err constant 0; BUSY waits indefinitely.

Decomposition:
- Shared header ecc_defs.vh holds:
  - the coordinate width constant (256);
  - the arbiter state encodings;
  - the default TIMEOUT_CYC.
- One sub-module, rr_pick: combinational round-robin selector with inputs req[NREQ] and ptr, and outputs a one-hot grant and an encoded index.
- The FSM, operand/result registers and watchdog stay in ecc_add_arbiter.

Test Plan:
- Bench setup: add unit model with fixed L=10 that returns Rx=Px+Qx and Ry=Py+Qy (mod 2^256).
- Single request: req_valid=01, P=(1,2), Q=(3,4) at t=5 -> req_ready=01 at t=5; add_in_valid at t=6; resp_valid=01 at t=17 with resp_Rx=4, resp_Ry=6.
- Contention: both requesters valid continuously for 4 ops from reset -> grant order 0,1,0,1; each resp_valid bit matches its owner's result.
- Operand stability: change req_P* of requester 0 after accept -> add_P* unchanged through BUSY; result uses the latched values.
- Reset in BUSY: assert rst 1 cycle at t=10 of an op, model still fires out_valid at t=17 -> no resp_valid; rr_ptr=0; next request accepted normally.
- Wrap values: Px=Qx=2^256-1 -> resp_Rx=2^256-2 (full width passes unaltered).
- ARB_TIMEOUT_EN, TIMEOUT_CYC=16, model never responds -> resp_valid with resp_err=1 at ISSUE+17, then DRAIN for 16 cycles, then IDLE; next request accepted normally.

Source files
------------

// File: rtl/ecc_add_arbiter_pkg.sv
// ecc_add_arbiter_pkg: shared constants and state encoding for the
// elliptic-curve point-add arbiter.
package ecc_add_arbiter_pkg;

    // Coordinate width of the shared point-add unit.
    localparam int COORD_W = 256;

    // Default watchdog limit, used only when ARB_TIMEOUT_EN is defined.
    localparam int TIMEOUT_CYC_DEF = 4096;

    // Arbiter FSM states. ST_DRAIN is reachable only with ARB_TIMEOUT_EN.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_BUSY  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } arb_state_e;

    // Index width for n requesters; never zero, so NREQ=1 still has a 1-bit pointer.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ecc_add_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector. Searches req_i starting at
// ptr_i and wrapping modulo NREQ; returns the first set bit as a one-hot
// grant and as an encoded index.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // First requester at or after the pointer, wrapping once around.
    always_comb begin
        int  pos;
        logic found;
        pos     = 0;
        found   = 1'b0;
        grant_o = '0;
        idx_o   = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!found && req_i[pos]) begin
                found        = 1'b1;
                grant_o[pos] = 1'b1;
                idx_o        = IW'(pos);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ecc_add_arbiter.sv
// ecc_add_arbiter: shares one 256-bit EC point-add unit among NREQ
// requesters with round-robin arbitration, one operation in flight.
// Optional watchdog: define ARB_TIMEOUT_EN to abort a hung add after
// TIMEOUT_CYC cycles (resp_err=1) and drain the late result before reuse.
//
// Handshake: a requester raises req_valid and holds its operands; the
// request is taken in the single cycle where req_valid and req_ready are
// both high (req_ready is combinational and only ever high in IDLE).
// Dropping req_valid before that cycle withdraws the request. Results come
// back as a one-cycle resp_valid strobe to the owner, with no back-pressure.
module ecc_add_arbiter
    import ecc_add_arbiter_pkg::*;
#(
    parameter int NREQ        = 2,
    parameter int W           = COORD_W,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*W-1:0]   req_Px,
    input  logic [NREQ*W-1:0]   req_Py,
    input  logic [NREQ*W-1:0]   req_Qx,
    input  logic [NREQ*W-1:0]   req_Qy,
    output logic [NREQ-1:0]     resp_valid,
    output logic [W-1:0]        resp_Rx,
    output logic [W-1:0]        resp_Ry,
    output logic                resp_err,
    output logic                busy,
    output logic                add_in_valid,
    output logic [W-1:0]        add_Px,
    output logic [W-1:0]        add_Py,
    output logic [W-1:0]        add_Qx,
    output logic [W-1:0]        add_Qy,
    input  logic [W-1:0]        add_Rx,
    input  logic [W-1:0]        add_Ry,
    input  logic                add_out_valid,
    output arb_state_e          dbg_state_o
);

    localparam int IW = idx_w(NREQ);

    arb_state_e       state_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    rr_ptr_d;
    logic [IW-1:0]    owner_q;
    logic [NREQ-1:0]  owner_oh;
    logic [W-1:0]     op_px_q, op_py_q, op_qx_q, op_qy_q;
    logic [W-1:0]     resp_rx_q, resp_ry_q;
    logic [NREQ-1:0]  resp_valid_q;
    logic             add_in_valid_q;
    logic [NREQ-1:0]  pick_grant;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0]  wd_q;
    logic             resp_err_q;
`endif

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    // Pointer after the current owner, and the owner as a one-hot strobe mask.
    always_comb begin
        rr_ptr_d = (int'(owner_q) == NREQ - 1) ? '0 : owner_q + IW'(1);
        owner_oh = '0;
        for (int i = 0; i < NREQ; i++) owner_oh[i] = (int'(owner_q) == i);
    end

    // Arbiter FSM: accept, issue, wait for the adder, respond (and drain after a timeout).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            op_px_q        <= '0;
            op_py_q        <= '0;
            op_qx_q        <= '0;
            op_qy_q        <= '0;
            resp_rx_q      <= '0;
            resp_ry_q      <= '0;
            resp_valid_q   <= '0;
            add_in_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wd_q           <= '0;
            resp_err_q     <= 1'b0;
`endif
        end else begin
            add_in_valid_q <= 1'b0;
            resp_valid_q   <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        op_px_q        <= req_Px[int'(pick_idx)*W +: W];
                        op_py_q        <= req_Py[int'(pick_idx)*W +: W];
                        op_qx_q        <= req_Qx[int'(pick_idx)*W +: W];
                        op_qy_q        <= req_Qy[int'(pick_idx)*W +: W];
                        owner_q        <= pick_idx;
                        add_in_valid_q <= 1'b1;
                        state_q        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                    wd_q    <= '0;
`endif
                end
                ST_BUSY: begin
                    if (add_out_valid) begin
                        resp_rx_q    <= add_Rx;
                        resp_ry_q    <= add_Ry;
                        resp_valid_q <= owner_oh;
                        op_px_q      <= '0;
                        op_py_q      <= '0;
                        op_qx_q      <= '0;
                        op_qy_q      <= '0;
                        state_q      <= ST_RESP;
`ifdef ARB_TIMEOUT_EN
                        resp_err_q   <= 1'b0;
                    end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        // Adder is hung: answer the owner with an error and zero result.
                        resp_rx_q    <= '0;
                        resp_ry_q    <= '0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= owner_oh;
                        op_px_q      <= '0;
                        op_py_q      <= '0;
                        op_qx_q      <= '0;
                        op_qy_q      <= '0;
                        state_q      <= ST_RESP;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
`endif
                    end
                end
                ST_RESP: begin
                    rr_ptr_q <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
                    wd_q     <= '0;
                    state_q  <= resp_err_q ? ST_DRAIN : ST_IDLE;
`else
                    state_q  <= ST_IDLE;
`endif
                end
`ifdef ARB_TIMEOUT_EN
                ST_DRAIN: begin
                    // Swallow the late result (or give up) before the adder is reused.
                    if (add_out_valid || wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        wd_q <= wd_q + WD_W'(1);
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Output decode: ready only in IDLE; everything else comes straight from registers.
    assign req_ready    = (state_q == ST_IDLE) ? pick_grant : '0;
    assign busy         = (state_q != ST_IDLE);
    assign add_in_valid = add_in_valid_q;
    assign add_Px       = op_px_q;
    assign add_Py       = op_py_q;
    assign add_Qx       = op_qx_q;
    assign add_Qy       = op_qy_q;
    assign resp_valid   = resp_valid_q;
    assign resp_Rx      = resp_rx_q;
    assign resp_Ry      = resp_ry_q;
    assign dbg_state_o  = state_q;
`ifdef ARB_TIMEOUT_EN
    assign resp_err     = resp_err_q;
`else
    assign resp_err     = 1'b0;
`endif

endmodule
